ram_burst_ctrl: RTL
===================

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 Parameter ADDR_W, default 6, SHALL set the RAM address width (64 words).
REQ-002 Parameter DATA_W, default 8, SHALL set the RAM data width.
REQ-003 Parameter LEN_W, default 4, SHALL set the burst-length field width; bursts are 1..16 beats.
REQ-004 The port list SHALL be, in this order:
 - clk  in  1  sole clock; all logic on the rising edge
 - reset  in  1  asynchronous, active-high
 - cmd_valid  in  1  command offered
 - cmd_ready  out  1  command accepted when high together with cmd_valid
 - cmd_write  in  1  1 = write burst, 0 = read burst
 - cmd_addr  in  ADDR_W  burst start address
 - cmd_len  in  LEN_W  beats minus one
 - wr_valid  in  1  write beat offered
 - wr_ready  out  1  write beat accepted
 - wr_data  in  DATA_W  write beat data
 - rd_valid  out  1  read beat available
 - rd_ready  in  1  consumer accepts read beat
 - rd_data  out  DATA_W  read beat data
 - rd_last  out  1  final beat of the read burst
 - busy  out  1  burst in progress
 - ram_we  out  1  RAM write enable
 - ram_addr  out  ADDR_W  RAM address
 - ram_din  out  DATA_W  RAM write data
 - ram_dout  in  DATA_W  RAM registered read data, valid one cycle after a we=0 cycle

Function
REQ-005 The FSM SHALL have states IDLE, WR and RD; busy SHALL be 1 in any state other than IDLE.
REQ-006 cmd_ready SHALL be 1 only in IDLE; on a handshake, the block SHALL latch cmd_addr into the address register and cmd_len into the beat counter, then enter WR if cmd_write=1, otherwise RD.
REQ-007 In WR: wr_ready=1, ram_we=wr_valid, ram_din=wr_data, ram_addr=address register; each wr_valid cycle is one beat.
REQ-008 On each write beat, the address SHALL increment modulo 2^ADDR_W (63 wraps to 0) and the counter SHALL decrement; the block SHALL return to IDLE after the beat at count 0.
REQ-009 In WR with wr_valid=0, ram_we SHALL be 0 and the address and counter SHALL hold.
REQ-010 ram_we SHALL be 0 in every state other than WR.
REQ-011 In RD, a read SHALL be issued by driving ram_addr with ram_we=0 only when (fifo_count - pop_this_cycle + inflight) < 2.
REQ-012 Each read issue SHALL set inflight for the next cycle, advance the address (with wrap) and decrement the remaining-issue count.
REQ-013 When inflight=1, ram_dout SHALL be pushed into a 2-entry read FIFO, tagged last if it is the final beat.
REQ-014 rd_valid SHALL equal FIFO non-empty; rd_data and rd_last SHALL come from the FIFO head; rd_valid&&rd_ready pops the head.
REQ-015 RD SHALL return to IDLE on the cycle the last-tagged beat pops.
REQ-016 Latency: with rd_ready held high, the first rd_valid SHALL occur in the third cycle after the accept cycle; throughput SHALL then be one beat per cycle.
REQ-017 A simultaneous push and pop on a full FIFO SHALL be legal; the FIFO SHALL never overflow or underflow.
REQ-018 wr_valid in RD/IDLE and rd_ready outside RD SHALL be ignored.

Reset
REQ-019 Asserting reset SHALL immediately force IDLE, an empty FIFO, inflight=0, address=0 and counter=0; outputs SHALL be cmd_ready=1 and all other outputs 0.
REQ-020 Reset mid-burst SHALL abort the burst; RAM contents already written SHALL remain, and no rd_valid SHALL appear after deassertion.

Structure
REQ-021 Package ram_ctrl_pkg SHALL hold ADDR_W, DATA_W and LEN_W defaults and the FSM state encoding.
REQ-022 The read FIFO SHALL be sub-module rd_skid_fifo (2 entries, DATA_W+1 bits wide, same clk/reset).

Verification
REQ-023 Write addr=5, len=3, data 11,22,33,44 contiguous -> ram_we for 4 cycles at addr 5..8; busy falls after the 4th beat.
REQ-024 Read addr=5, len=3, rd_ready=1 -> 11,22,33,44 on consecutive cycles from the 3rd cycle after accept; rd_last with 44.
REQ-025 Write addr=62, len=3 -> addresses 62,63,0,1; a read-back returns the same data.
REQ-026 Read len=15 with rd_ready toggled 1/0 -> all 16 beats in order, no loss or duplicate, at most 2 reads outstanding.
REQ-027 Write burst with wr_valid gaps -> ram_we only on wr_valid cycles, and the address holds during gaps.
REQ-028 reset asserted mid read burst -> immediate IDLE, rd_valid=0, cmd_ready=1; a new command is accepted after deassertion.

Source files
------------

// File: rtl/ram_ctrl_pkg.sv
// Shared defaults and FSM encoding for the RAM burst controller.
package ram_ctrl_pkg;

  localparam int DEF_ADDR_W = 6;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2
  } state_t;

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry read-return FIFO; push and pop in the same cycle are legal even when full.
module rd_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic [1:0]   count
);

  logic [W-1:0] r_mem [2];
  logic         r_wptr;
  logic         r_rptr;
  logic [1:0]   r_count;
  logic         w_push;
  logic         w_pop;

  // Guards make overflow/underflow impossible even if the caller misbehaves.
  assign w_pop  = pop && (r_count != 2'd0);
  assign w_push = push && ((r_count != 2'd2) || w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= din;
        r_wptr        <= ~r_wptr;
      end
      if (w_pop) begin
        r_rptr <= ~r_rptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign dout  = r_mem[r_rptr];
  assign empty = (r_count == 2'd0);
  assign count = r_count;

endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of a single-port RAM with registered read data.
// Reads are throttled so FIFO occupancy plus the in-flight read never exceeds two.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_cnt;
  logic              r_issue_done;
  logic              r_inflight;
  logic              r_inflight_last;

  logic [DATA_W:0]   w_fifo_dout;
  logic              w_fifo_empty;
  logic [1:0]        w_fifo_count;
  logic              w_pop;
  logic              w_issue;
  logic [2:0]        w_occ;
  logic              w_rd_valid;

  assign w_rd_valid = ~w_fifo_empty;
  assign w_pop      = (r_state == ST_RD) && w_rd_valid && rd_ready;
  assign w_occ      = {1'b0, w_fifo_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue    = (r_state == ST_RD) && !r_issue_done && (w_occ < 3'd2);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_addr          <= '0;
      r_cnt           <= '0;
      r_issue_done    <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
    end else begin
      r_inflight      <= w_issue;
      r_inflight_last <= w_issue && (r_cnt == '0);
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            r_addr       <= cmd_addr;
            r_cnt        <= cmd_len;
            r_issue_done <= 1'b0;
            r_state      <= cmd_write ? ST_WR : ST_RD;
          end
        end
        ST_WR: begin
          if (wr_valid) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_cnt == '0) begin
              r_state <= ST_IDLE;
            end else begin
              r_cnt <= r_cnt - LEN_W'(1);
            end
          end
        end
        ST_RD: begin
          if (w_issue) begin
            r_addr <= r_addr + ADDR_W'(1);
            if (r_cnt == '0) begin
              r_issue_done <= 1'b1;
            end else begin
              r_cnt <= r_cnt - LEN_W'(1);
            end
          end
          // Last beat leaving the FIFO implies nothing else is queued or in flight.
          if (w_pop && w_fifo_dout[DATA_W]) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  rd_skid_fifo #(
    .W (DATA_W + 1)
  ) u_rd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (r_inflight),
    .din   ({r_inflight_last, ram_dout}),
    .pop   (w_pop),
    .dout  (w_fifo_dout),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign wr_ready  = (r_state == ST_WR);
  assign ram_we    = (r_state == ST_WR) && wr_valid;
  assign ram_din   = (r_state == ST_WR) ? wr_data : '0;
  assign ram_addr  = r_addr;
  assign rd_valid  = w_rd_valid;
  assign rd_data   = w_fifo_dout[DATA_W-1:0];
  assign rd_last   = w_fifo_dout[DATA_W];

endmodule
